// File: rtl/m_axi_pkg.sv
// Shared AXI constants and the read-arbiter state encoding.
package m_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    REJ  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin selector: first asserted request at or above the
// pointer, wrapping modulo NUM_REQ.
module rr_grant #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_cand;

  // Scan from the pointer upward and keep the first hit only
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 AR/R channel pair between NUM_REQ
// burst engines; one burst in flight, 4 KB-crossing requests are rejected.
module m_axi_rd_arbiter
  import m_axi_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]          req_arlen,
  output logic [NUM_REQ-1:0]            req_arready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]            req_rvalid,
  output logic                          req_rlast,
  output logic [1:0]                    req_rresp,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [ID_WIDTH-1:0]           m_axi_arid,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [ID_WIDTH-1:0]           m_axi_rid,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic                          busy
);

  localparam int unsigned IDX_W      = $clog2(NUM_REQ);
  localparam logic [13:0] BEAT_BYTES = 14'(DATA_WIDTH / 8);

  arb_state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]        r_gnt, w_gnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [7:0]              r_len, w_len_nxt;

  logic [NUM_REQ-1:0]      w_onehot;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_any;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [7:0]              w_sel_len;
  logic [13:0]             w_span;
  logic [13:0]             w_end;
  logic                    w_cross;
  logic [IDX_W-1:0]        w_ptr_inc;
  logic                    w_unused_rid;

  // The slave's RID is not cross-checked against the grant
  assign w_unused_rid = ^m_axi_rid;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .i_req (req_arvalid),
    .i_ptr (r_ptr),
    .o_gnt (w_onehot),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_sel_addr = req_araddr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_len  = req_arlen[w_idx*8 +: 8];

  // 14-bit sum: up to 4095 + 256 beats * bytes per beat without overflow
  assign w_span  = (14'(w_sel_len) + 14'd1) * BEAT_BYTES;
  assign w_end   = 14'(w_sel_addr[11:0]) + w_span;
  assign w_cross = w_end > 14'(BOUNDARY_4K);

  assign w_ptr_inc = (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;

  assign m_axi_arid    = ID_WIDTH'(r_gnt);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = AXI_BURST_INCR;
  assign busy          = (r_state != IDLE);

  // State register
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, pointer and latched request
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_addr <= '0;
      r_len  <= '0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_gnt  <= w_gnt_nxt;
      r_addr <= w_addr_nxt;
      r_len  <= w_len_nxt;
    end
  end

  // Next state and all channel outputs; everything idles low while in reset
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_nxt     = r_gnt;
    w_addr_nxt    = r_addr;
    w_len_nxt     = r_len;
    req_arready   = '0;
    req_err       = '0;
    req_rvalid    = '0;
    req_rdata     = '0;
    req_rlast     = 1'b0;
    req_rresp     = RESP_OKAY;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    if (!m_axi_areset) begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            w_gnt_nxt   = w_idx;
            w_addr_nxt  = w_sel_addr;
            w_len_nxt   = w_sel_len;
            req_arready = w_onehot;
            if (w_cross) begin
              req_err     = w_onehot;
              w_state_nxt = REJ;
            end else begin
              w_state_nxt = ADDR;
            end
          end
        end
        ADDR: begin
          m_axi_arvalid = 1'b1;
          if (m_axi_arready) begin
            w_state_nxt = DATA;
          end
        end
        DATA: begin
          m_axi_rready      = req_rready[r_gnt];
          req_rvalid[r_gnt] = m_axi_rvalid;
          req_rdata         = m_axi_rdata;
          req_rresp         = m_axi_rresp;
          req_rlast         = m_axi_rlast;
          if (m_axi_rvalid && req_rready[r_gnt] && m_axi_rlast) begin
            w_ptr_nxt   = w_ptr_inc;
            w_state_nxt = IDLE;
          end
        end
        REJ: begin
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
